// File: rtl/nv_nvdla_rst_seq_pkg.sv
// Shared types and helpers for the NVDLA partition reset sequencer.
package nv_nvdla_rst_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StAssert,
    StRelease,
    StDone
  } rst_seq_state_e;

  // Wide enough for the longest dwell of any state, so the shared counter never wraps in-state.
  function automatic int unsigned cnt_w(input int unsigned drain_tmo,
                                        input int unsigned hold_cyc,
                                        input int unsigned num_part,
                                        input int unsigned gap_cyc);
    int unsigned m;
    m = drain_tmo;
    if (hold_cyc > m) m = hold_cyc;
    if (num_part * gap_cyc > m) m = num_part * gap_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nv_nvdla_rst_seq_if.sv
// Control/status bundle between the CSB/partition side and the reset sequencer.
interface nv_nvdla_rst_seq_if #(
  parameter int unsigned NUM_PART = 4
);
  logic                test_mode;
  logic                soft_rst_req;
  logic [NUM_PART-1:0] part_idle;
  logic [NUM_PART-1:0] part_rstn;
  logic                rst_busy;
  logic                rst_done;
  logic                drain_tmo_err;
  logic                req_dropped;

  modport master (
    output test_mode, soft_rst_req, part_idle,
    input  part_rstn, rst_busy, rst_done, drain_tmo_err, req_dropped
  );

  modport slave (
    input  test_mode, soft_rst_req, part_idle,
    output part_rstn, rst_busy, rst_done, drain_tmo_err, req_dropped
  );
endinterface

// File: rtl/nv_nvdla_rst_seq_cnt.sv
// Clearable up-counter with terminal-compare output, shared by all sequencer states.
module nv_nvdla_rst_seq_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] cnt,
  output logic             hit
);

  // Saturates so a long IDLE dwell cannot roll over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/nv_nvdla_rst_seq.sv
// Staged partition reset sequencer: power-on and soft-reset drain, hold and in-order release.
module nv_nvdla_rst_seq
  import nv_nvdla_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_PART  = 4,
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned DRAIN_TMO = 1024
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  nv_nvdla_rst_seq_if.slave    bus
);

  localparam int unsigned CntW = cnt_w(DRAIN_TMO, HOLD_CYC, NUM_PART, GAP_CYC);

  rst_seq_state_e      state_q, state_d;
  logic [CntW-1:0]     cnt, term;
  logic                hit, adv;
  logic [NUM_PART-1:0] part_rstn_q, rel_set;
  logic                busy_q, done_q, tmo_q, drop_q;

  always_comb begin
    state_d = state_q;
    term    = '0;
    case (state_q)
      StIdle: begin
        if (bus.soft_rst_req) state_d = StDrain;
      end
      StDrain: begin
        term = CntW'(DRAIN_TMO - 1);
        if ((&bus.part_idle) || hit) state_d = StAssert;
      end
      StAssert: begin
        term = CntW'(HOLD_CYC - 1);
        if (hit) state_d = StRelease;
      end
      StRelease: begin
        term = CntW'((NUM_PART - 1) * GAP_CYC);
        if (hit) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StAssert;
    endcase
  end

  assign adv = (state_d != state_q);

  nv_nvdla_rst_seq_cnt #(
    .WIDTH (CntW)
  ) u_cnt (
    .clk   (nvdla_core_clk),
    .rst_n (nvdla_core_rstn),
    .clr   (adv),
    .term  (term),
    .cnt   (cnt),
    .hit   (hit)
  );

  // Bit i goes high on the edge that makes RELEASE cycle i*GAP_CYC current.
  assign rel_set[0] = 1'b0;
  for (genvar g = 1; g < NUM_PART; g++) begin : g_rel
    assign rel_set[g] = ((32'(cnt) + 32'd1) == g * GAP_CYC);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= StAssert;
      part_rstn_q <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      if (bus.soft_rst_req && (state_q != StIdle)) drop_q <= 1'b1;
      case (state_q)
        StIdle: begin
          part_rstn_q <= '1;
          if (bus.soft_rst_req) begin
            tmo_q  <= 1'b0;
            drop_q <= 1'b0;
          end
        end
        StDrain: begin
          if (adv) part_rstn_q <= '0;
          if (!(&bus.part_idle) && hit) tmo_q <= 1'b1;
        end
        StAssert: begin
          part_rstn_q <= adv ? NUM_PART'(1) : '0;
        end
        StRelease: begin
          part_rstn_q <= part_rstn_q | rel_set;
        end
        StDone: begin
          part_rstn_q <= '1;
        end
        default: begin
          part_rstn_q <= '0;
        end
      endcase
    end
  end

  assign bus.part_rstn     = bus.test_mode ? {NUM_PART{nvdla_core_rstn}} : part_rstn_q;
  assign bus.rst_busy      = busy_q;
  assign bus.rst_done      = done_q;
  assign bus.drain_tmo_err = tmo_q;
  assign bus.req_dropped   = drop_q;

endmodule

// File: tb/tb_nv_nvdla_rst_seq.sv
// Directed bench for the partition reset sequencer: vector tables plus async/test-mode corners.
module tb_nv_nvdla_rst_seq;

  typedef struct {
    string      name;
    logic       req;
    logic [3:0] idle;
    int         adv;
    logic [3:0] exp_rstn;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_tmo;
    logic       exp_drop;
  } vec_t;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  vec_t vecs[$];

  nv_nvdla_rst_seq_if #(.NUM_PART(4)) bus ();

  nv_nvdla_rst_seq #(
    .NUM_PART  (4),
    .HOLD_CYC  (16),
    .GAP_CYC   (4),
    .DRAIN_TMO (1024)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input string name, input logic req, input logic [3:0] idle,
                              input int adv, input logic [3:0] r, input logic b,
                              input logic d, input logic t, input logic p);
    vec_t v;
    v.name = name; v.req = req; v.idle = idle; v.adv = adv;
    v.exp_rstn = r; v.exp_busy = b; v.exp_done = d; v.exp_tmo = t; v.exp_drop = p;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [3:0] r, input logic b, input logic d,
                         input logic t, input logic p);
    chk({name, ".part_rstn"}, 32'(bus.part_rstn), 32'(r));
    chk({name, ".rst_busy"}, 32'(bus.rst_busy), 32'(b));
    chk({name, ".rst_done"}, 32'(bus.rst_done), 32'(d));
    chk({name, ".drain_tmo_err"}, 32'(bus.drain_tmo_err), 32'(t));
    chk({name, ".req_dropped"}, 32'(bus.req_dropped), 32'(p));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bus.soft_rst_req = vecs[i].req;
      bus.part_idle    = vecs[i].idle;
      tick();
      bus.soft_rst_req = 1'b0;
      repeat (vecs[i].adv - 1) tick();
      chk_all(vecs[i].name, vecs[i].exp_rstn, vecs[i].exp_busy, vecs[i].exp_done,
              vecs[i].exp_tmo, vecs[i].exp_drop);
    end
  endtask

  int po_lo, po_hi, tmo_hi, drop_hi, soft_hi;

  initial begin
    checks   = 0;
    failures = 0;

    // Power-on: starts from rstn released between two edges.
    po_lo = vecs.size();
    add("po_assert1",  1'b0, 4'hF,  1, 4'h0, 1, 0, 0, 0);
    add("po_assert15", 1'b0, 4'hF, 14, 4'h0, 1, 0, 0, 0);
    add("po_rel0",     1'b0, 4'hF,  1, 4'h1, 1, 0, 0, 0);
    add("po_rel3",     1'b0, 4'hF,  3, 4'h1, 1, 0, 0, 0);
    add("po_rel4",     1'b0, 4'hF,  1, 4'h3, 1, 0, 0, 0);
    add("po_rel8",     1'b0, 4'hF,  4, 4'h7, 1, 0, 0, 0);
    add("po_rel11",    1'b0, 4'hF,  3, 4'h7, 1, 0, 0, 0);
    add("po_rel12",    1'b0, 4'hF,  1, 4'hF, 1, 0, 0, 0);
    add("po_done",     1'b0, 4'hF,  1, 4'hF, 1, 1, 0, 0);
    add("po_idle",     1'b0, 4'hF,  1, 4'hF, 0, 0, 0, 0);
    po_hi = vecs.size();
    // Drain timeout with partition 3 never idle.
    add("tmo_drain_last", 1'b1, 4'h7, 1024, 4'hF, 1, 0, 0, 0);
    add("tmo_assert0",    1'b0, 4'h7,    1, 4'h0, 1, 0, 1, 0);
    add("tmo_assert15",   1'b0, 4'h7,   15, 4'h0, 1, 0, 1, 0);
    add("tmo_rel0",       1'b0, 4'h7,    1, 4'h1, 1, 0, 1, 0);
    add("tmo_rel12",      1'b0, 4'h7,   12, 4'hF, 1, 0, 1, 0);
    add("tmo_done",       1'b0, 4'h7,    1, 4'hF, 1, 1, 1, 0);
    add("tmo_idle",       1'b0, 4'h7,    1, 4'hF, 0, 0, 1, 0);
    tmo_hi = vecs.size();
    // Request dropped during RELEASE; accepted request clears the timeout flag.
    add("drop_drain",   1'b1, 4'hF,  1, 4'hF, 1, 0, 0, 0);
    add("drop_assert0", 1'b0, 4'hF,  1, 4'h0, 1, 0, 0, 0);
    add("drop_rel0",    1'b0, 4'hF, 16, 4'h1, 1, 0, 0, 0);
    add("drop_flag",    1'b1, 4'hF,  1, 4'h1, 1, 0, 0, 1);
    add("drop_rel4",    1'b0, 4'hF,  3, 4'h3, 1, 0, 0, 1);
    add("drop_rel12",   1'b0, 4'hF,  8, 4'hF, 1, 0, 0, 1);
    add("drop_done",    1'b0, 4'hF,  1, 4'hF, 1, 1, 0, 1);
    add("drop_idle",    1'b0, 4'hF,  1, 4'hF, 0, 0, 0, 1);
    drop_hi = vecs.size();
    // Clean soft reset with everything idle; clears req_dropped.
    add("soft_drain",    1'b1, 4'hF,  1, 4'hF, 1, 0, 0, 0);
    add("soft_assert0",  1'b0, 4'hF,  1, 4'h0, 1, 0, 0, 0);
    add("soft_assert15", 1'b0, 4'hF, 15, 4'h0, 1, 0, 0, 0);
    add("soft_rel0",     1'b0, 4'hF,  1, 4'h1, 1, 0, 0, 0);
    add("soft_rel4",     1'b0, 4'hF,  4, 4'h3, 1, 0, 0, 0);
    add("soft_rel8",     1'b0, 4'hF,  4, 4'h7, 1, 0, 0, 0);
    add("soft_rel12",    1'b0, 4'hF,  4, 4'hF, 1, 0, 0, 0);
    add("soft_done",     1'b0, 4'hF,  1, 4'hF, 1, 1, 0, 0);
    add("soft_idle",     1'b0, 4'hF,  1, 4'hF, 0, 0, 0, 0);
    soft_hi = vecs.size();

    rstn             = 1'b0;
    bus.test_mode    = 1'b0;
    bus.soft_rst_req = 1'b0;
    bus.part_idle    = 4'hF;
    repeat (3) tick();
    chk_all("reset", 4'h0, 1, 0, 0, 0);
    rstn = 1'b1;

    run_range(po_lo, po_hi);
    run_range(po_hi, tmo_hi);
    run_range(tmo_hi, drop_hi);
    run_range(drop_hi, soft_hi);

    // Reset asserted on RELEASE cycle 5.
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    repeat (17) tick();
    repeat (5) tick();
    chk("mid_rel5.part_rstn", 32'(bus.part_rstn), 32'h3);
    #2 rstn = 1'b0;
    #1 chk_all("mid_async", 4'h0, 1, 0, 0, 0);
    tick();
    chk("mid_held.part_rstn", 32'(bus.part_rstn), 32'h0);
    rstn = 1'b1;
    run_range(po_lo, po_hi);

    // Test-mode bypass: part_rstn follows rstn between clock edges.
    bus.test_mode = 1'b1;
    #1 chk("tm_high.part_rstn", 32'(bus.part_rstn), 32'hF);
    rstn = 1'b0;
    #1 chk("tm_low.part_rstn", 32'(bus.part_rstn), 32'h0);
    rstn = 1'b1;
    #1 chk("tm_rise.part_rstn", 32'(bus.part_rstn), 32'hF);
    bus.test_mode = 1'b0;
    #1 chk("tm_off.part_rstn", 32'(bus.part_rstn), 32'h0);
    run_range(po_lo, po_hi);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
